timer_counter: RTL

Memory-mapped countdown timer sitting directly downstream of the data-memory stage. It is written when the store path raises its peripheral write-enable for timer addresses (0x7f00–0x7f0b, 0x7f10–0x7f1b), and read back through the same bridge on loads. Two instances are instantiated, one per window; each exposes CTRL, PRESET and COUNT registers and drives an interrupt request toward the CP0 stage.

---
 rtl/timer_counter_pkg.sv | 33 +++
 rtl/timer_counter.sv | 95 +++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register
// offsets, CTRL field positions, mode codes and the FSM state encoding.
package timer_counter_pkg;

  // Word offsets within one timer window (bridge passes Addr[3:2]).
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE codes; any code other than auto-reload behaves as one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Timer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // True only for the auto-reload code; 1x falls back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with CTRL / PRESET / COUNT registers and a maskable
// interrupt. One instance serves one address window of the bridge.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  state_t      state;

  // Timer FSM plus register writes; a bus write on the same edge as a
  // hardware update takes priority over it.
  // NOTE: non-blocking assignments make every read here see the pre-edge
  // value, and a later assignment to the same register in this block wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      mode     <= MODE_ONESHOT;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count <= 32'd1) begin
            // PRESET of 0 or 1 both expire here without wrapping.
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        ST_INT: begin
          state <= ST_IDLE;
          if (is_reload(mode)) irq_flag <= 1'b0;
          else                 en       <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // Bus writes come last so they override the hardware EN clear.
      if (we) begin
        case (addr)
          OFF_CTRL: begin
            en       <= wdata[CTRL_EN_BIT];
            mode     <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
            im       <= wdata[CTRL_IM_BIT];
            irq_flag <= 1'b0;
          end
          OFF_PRESET: preset <= wdata;
          default: ;  // COUNT is read-only, offset 3 is unused
        endcase
      end
    end
  end

  // Zero-latency read mux for the word selected by addr.
  // NOTE: rdata gets a default before the case so no latch is inferred.
  always_comb begin
    rdata = '0;
    case (addr)
      OFF_CTRL:   rdata = {28'd0, im, mode, en};
      OFF_PRESET: rdata = preset;
      OFF_COUNT:  rdata = count;
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_flag & im;

endmodule
